nx_node_store_mp: RTL and testbench

//  Multi-reader node memory: one write stream (decoder load) and RD_PORTS

---
 rtl/nx_node_store_mp_pkg.sv | 14 +
 rtl/nx_ram.sv | 35 +++
 rtl/nx_store_rr_pick.sv | 44 ++++
 rtl/nx_node_store_mp.sv | 134 +++++++++++++
 tb/tb_nx_node_store_mp.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nx_node_store_mp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : nx_node_store_mp_pkg                                      |
// | Description : Global NX widths shared by the node-store blocks.         |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
package nx_node_store_mp_pkg;
    localparam int c_ram_addr_w   = 10;
    localparam int c_ram_data_w   = 32;
    localparam int c_rd_ports     = 3;
    localparam int c_wr_burst_max = 4;
    localparam int c_burst_cnt_w  = 4;
endpackage
`default_nettype wire

// File: rtl/nx_ram.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : nx_ram                                                    |
// | Description : True dual-port RAM, synchronous read-first, 1-cycle read. |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module nx_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_we_a,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [DATA_W-1:0] i_wdata_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic              i_we_b,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [DATA_W-1:0] i_wdata_b,
    output logic [DATA_W-1:0] o_rdata_b
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata_a_q;
    logic [DATA_W-1:0] r_rdata_b_q;

    always_ff @(posedge i_clk) begin
        if (i_we_a) r_mem[i_addr_a] <= i_wdata_a;
        if (i_we_b) r_mem[i_addr_b] <= i_wdata_b;
        r_rdata_a_q <= r_mem[i_addr_a];
        r_rdata_b_q <= r_mem[i_addr_b];
    end

    assign o_rdata_a = r_rdata_a_q;
    assign o_rdata_b = r_rdata_b_q;
endmodule
`default_nettype wire

// File: rtl/nx_store_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : nx_store_rr_pick                                          |
// | Description : Round-robin pick of up to two readers (port B, port A).   |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module nx_store_rr_pick
    import nx_node_store_mp_pkg::*;
#(
    parameter int N_PORTS = c_rd_ports,
    parameter int PTR_W   = 2
) (
    input  logic [N_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    input  logic               i_a_avail,
    output logic [N_PORTS-1:0] o_gnt_b,
    output logic [N_PORTS-1:0] o_gnt_a
);
    logic [N_PORTS-1:0] w_rot;
    logic [N_PORTS-1:0] w_rot_b;
    logic [N_PORTS-1:0] w_rot_a;
    logic               w_found;

    // Rotate so bit 0 is the pointer's client, pick in ascending order, rotate back.
    always_comb begin
        w_rot   = N_PORTS'({i_req, i_req} >> i_ptr);
        w_rot_b = '0;
        w_rot_a = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (w_rot[k]) begin
                if (!w_found) begin
                    w_rot_b[k] = 1'b1;
                    w_found    = 1'b1;
                end else if (i_a_avail && (w_rot_a == '0)) begin
                    w_rot_a[k] = 1'b1;
                end
            end
        end
        o_gnt_b = N_PORTS'({w_rot_b, w_rot_b} >> (N_PORTS - int'(i_ptr)));
        o_gnt_a = N_PORTS'({w_rot_a, w_rot_a} >> (N_PORTS - int'(i_ptr)));
    end
endmodule
`default_nettype wire

// File: rtl/nx_node_store_mp.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : nx_node_store_mp                                          |
// | Description : One writer and RD_PORTS readers sharing a dual-port RAM.  |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module nx_node_store_mp
    import nx_node_store_mp_pkg::*;
#(
    parameter int RAM_ADDR_W   = c_ram_addr_w,
    parameter int RAM_DATA_W   = c_ram_data_w,
    parameter int RD_PORTS     = c_rd_ports,
    parameter int WR_BURST_MAX = c_wr_burst_max
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [RAM_ADDR_W-1:0]                i_wr_addr,
    input  logic [RAM_DATA_W-1:0]                i_wr_data,
    input  logic                                 i_wr_en,
    output logic                                 o_wr_ready,
    input  logic [RD_PORTS-1:0][RAM_ADDR_W-1:0]  i_rd_addr,
    input  logic [RD_PORTS-1:0]                  i_rd_en,
    output logic [RD_PORTS-1:0]                  o_rd_stall,
    output logic [RD_PORTS-1:0]                  o_rd_valid,
    output logic [RD_PORTS-1:0][RAM_DATA_W-1:0]  o_rd_data
);
    localparam int c_ptr_w = $clog2(RD_PORTS);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_A    = 2'd1,
        TAG_B    = 2'd2
    } tag_e;

    logic [c_burst_cnt_w-1:0]            r_burst_cnt_q, w_burst_cnt_d;
    logic [c_ptr_w-1:0]                  r_rr_ptr_q, w_rr_ptr_d;
    tag_e                                r_tag_q [RD_PORTS];
    tag_e                                w_tag_d [RD_PORTS];
    logic [RD_PORTS-1:0][RAM_DATA_W-1:0] r_data_q, w_data_d;

    logic                  w_wr_block, w_wr_grant, w_a_avail;
    logic [RD_PORTS-1:0]   w_eligible, w_gnt_a, w_gnt_b, w_gnt, w_valid;
    logic [RAM_ADDR_W-1:0] w_addr_a, w_addr_b;
    logic [RAM_DATA_W-1:0] w_rdata_a, w_rdata_b;
    logic [c_ptr_w-1:0]    w_last_a, w_last_b, w_last;

    // A reader hitting this cycle's write address waits so it sees the new data.
    always_comb begin
        w_wr_block = (r_burst_cnt_q == c_burst_cnt_w'(WR_BURST_MAX));
        o_wr_ready = !i_rst && !w_wr_block;
        w_wr_grant = i_wr_en && o_wr_ready;
        w_a_avail  = !w_wr_grant;
        for (int n = 0; n < RD_PORTS; n++) begin
            w_eligible[n] = !i_rst && i_rd_en[n] &&
                            !(w_wr_grant && (i_rd_addr[n] == i_wr_addr));
        end
    end

    nx_store_rr_pick #(
        .N_PORTS (RD_PORTS),
        .PTR_W   (c_ptr_w)
    ) u_pick (
        .i_req     (w_eligible),
        .i_ptr     (r_rr_ptr_q),
        .i_a_avail (w_a_avail),
        .o_gnt_b   (w_gnt_b),
        .o_gnt_a   (w_gnt_a)
    );

    always_comb begin
        w_gnt      = w_gnt_a | w_gnt_b;
        o_rd_stall = i_rd_en & ~w_gnt;
        w_addr_a   = i_wr_addr;
        w_addr_b   = '0;
        w_last_a   = '0;
        w_last_b   = '0;
        for (int n = 0; n < RD_PORTS; n++) begin
            if (w_gnt_b[n]) begin
                w_addr_b = i_rd_addr[n];
                w_last_b = c_ptr_w'(n);
            end
            if (w_gnt_a[n]) begin
                w_addr_a = i_rd_addr[n];
                w_last_a = c_ptr_w'(n);
            end
        end
        // The port A grant, when present, is the later one in round-robin order.
        w_last     = (|w_gnt_a) ? w_last_a : w_last_b;
        w_rr_ptr_d = r_rr_ptr_q;
        if (|w_gnt) begin
            w_rr_ptr_d = (w_last == c_ptr_w'(RD_PORTS - 1)) ? '0 : w_last + c_ptr_w'(1);
        end
        w_burst_cnt_d = (w_wr_grant && (|i_rd_en)) ? r_burst_cnt_q + c_burst_cnt_w'(1) : '0;
        for (int n = 0; n < RD_PORTS; n++) begin
            w_valid[n]    = (r_tag_q[n] != TAG_NONE);
            w_tag_d[n]    = w_gnt_b[n] ? TAG_B : (w_gnt_a[n] ? TAG_A : TAG_NONE);
            w_data_d[n]   = i_rst ? '0 :
                            !w_valid[n] ? r_data_q[n] :
                            ((r_tag_q[n] == TAG_A) ? w_rdata_a : w_rdata_b);
            o_rd_valid[n] = w_valid[n] && !i_rst;
        end
        o_rd_data = w_data_d;
    end

    nx_ram #(
        .ADDR_W (RAM_ADDR_W),
        .DATA_W (RAM_DATA_W)
    ) u_ram (
        .i_clk     (i_clk),
        .i_we_a    (w_wr_grant),
        .i_addr_a  (w_addr_a),
        .i_wdata_a (i_wr_data),
        .o_rdata_a (w_rdata_a),
        .i_we_b    (1'b0),
        .i_addr_b  (w_addr_b),
        .i_wdata_b ('0),
        .o_rdata_b (w_rdata_b)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_burst_cnt_q <= '0;
            r_rr_ptr_q    <= '0;
            r_data_q      <= '0;
            for (int n = 0; n < RD_PORTS; n++) r_tag_q[n] <= TAG_NONE;
        end else begin
            r_burst_cnt_q <= w_burst_cnt_d;
            r_rr_ptr_q    <= w_rr_ptr_d;
            r_data_q      <= w_data_d;
            r_tag_q       <= w_tag_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_nx_node_store_mp.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_nx_node_store_mp                                       |
// | Description : Self-checking bench for nx_node_store_mp.                 |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module tb_nx_node_store_mp;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NP = 3;
    localparam int BM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst = 1'b1;
    logic [AW-1:0]          wr_addr = '0;
    logic [DW-1:0]          wr_data = '0;
    logic                   wr_en = 1'b0;
    logic                   wr_ready;
    logic [NP-1:0][AW-1:0]  rd_addr = '0;
    logic [NP-1:0]          rd_en = '0;
    logic [NP-1:0]          rd_stall, rd_valid;
    logic [NP-1:0][DW-1:0]  rd_data;

    logic                   d2_wr_en = 1'b0;
    logic [AW-1:0]          d2_wr_addr = '0;
    logic [DW-1:0]          d2_wr_data = '0;
    logic                   d2_wr_ready;
    logic [1:0][AW-1:0]     d2_rd_addr = '0;
    logic [1:0]             d2_rd_en = '0;
    logic [1:0]             d2_rd_stall, d2_rd_valid;
    logic [1:0][DW-1:0]     d2_rd_data;

    nx_node_store_mp #(.RAM_ADDR_W(AW), .RAM_DATA_W(DW), .RD_PORTS(NP), .WR_BURST_MAX(BM)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_en(wr_en),
        .o_wr_ready(wr_ready), .i_rd_addr(rd_addr), .i_rd_en(rd_en), .o_rd_stall(rd_stall),
        .o_rd_valid(rd_valid), .o_rd_data(rd_data));

    nx_node_store_mp #(.RAM_ADDR_W(AW), .RAM_DATA_W(DW), .RD_PORTS(2), .WR_BURST_MAX(BM)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_wr_addr(d2_wr_addr), .i_wr_data(d2_wr_data), .i_wr_en(d2_wr_en),
        .o_wr_ready(d2_wr_ready), .i_rd_addr(d2_rd_addr), .i_rd_en(d2_rd_en), .o_rd_stall(d2_rd_stall),
        .o_rd_valid(d2_rd_valid), .o_rd_data(d2_rd_data));

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] mem [1024];
    int            rr = 0;
    int            burst = 0;
    bit            pend [NP];
    logic [DW-1:0] pend_data [NP];
    logic [DW-1:0] hold [NP];
    bit            prev_stall [NP];
    logic [AW-1:0] prev_addr [NP];

    logic [NP-1:0]         s_stall, s_valid;
    logic [NP-1:0][DW-1:0] s_data;
    logic                  s_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the main DUT: predict from the rules, compare, then advance the model.
    task automatic cycle();
        bit g [NP];
        bit gb [NP];
        int nfound, last, idx;
        bit wr_ok, wr_g, elig;
        logic [DW-1:0] exp_d;
        @(negedge clk);
        for (int n = 0; n < NP; n++) begin
            if (prev_stall[n])
                chk($sformatf("hold_proto%0d", n), {rd_en[n], rd_addr[n]}, {1'b1, prev_addr[n]});
        end
        wr_ok  = !rst && (burst != BM);
        wr_g   = wr_en && wr_ok;
        nfound = 0;
        last   = -1;
        for (int n = 0; n < NP; n++) begin g[n] = 1'b0; gb[n] = 1'b0; end
        for (int k = 0; k < NP; k++) begin
            idx  = (rr + k) % NP;
            elig = !rst && rd_en[idx] && !(wr_g && rd_addr[idx] == wr_addr);
            if (elig && nfound == 0) begin
                g[idx] = 1'b1; gb[idx] = 1'b1; last = idx; nfound = 1;
            end else if (elig && nfound == 1 && !wr_g) begin
                g[idx] = 1'b1; last = idx; nfound = 2;
            end
        end
        s_stall = rd_stall; s_valid = rd_valid; s_data = rd_data; s_ready = wr_ready;
        chk("wr_ready", wr_ready, wr_ok);
        for (int n = 0; n < NP; n++) begin
            exp_d = rst ? '0 : (pend[n] ? pend_data[n] : hold[n]);
            chk($sformatf("stall%0d", n), rd_stall[n], rd_en[n] && !g[n]);
            chk($sformatf("valid%0d", n), rd_valid[n], pend[n] && !rst);
            chk($sformatf("data%0d", n), rd_data[n], exp_d);
        end
        for (int n = 0; n < NP; n++) begin
            prev_stall[n] = !rst && rd_en[n] && !g[n];
            prev_addr[n]  = rd_addr[n];
            if (rst) begin
                pend[n] = 1'b0; hold[n] = '0;
            end else begin
                if (pend[n]) hold[n] = pend_data[n];
                pend[n] = g[n];
                if (g[n]) pend_data[n] = mem[rd_addr[n]];
            end
        end
        if (rst) begin
            rr = 0; burst = 0;
        end else begin
            if (last >= 0) rr = (last + 1) % NP;
            burst = (wr_g && (rd_en != '0)) ? burst + 1 : 0;
        end
        if (wr_g) mem[wr_addr] = wr_data;
        @(posedge clk);
        #1;
    endtask

    // Release requests only from clients that are not stalled.
    task automatic drain();
        for (int i = 0; i < 10 && rd_en != '0; i++) begin
            for (int n = 0; n < NP; n++) if (!prev_stall[n]) rd_en[n] = 1'b0;
            cycle();
        end
    endtask

    initial begin
        int acc, lows;
        int vcnt [NP];
        for (int n = 0; n < NP; n++) begin
            pend[n] = 1'b0; pend_data[n] = '0; hold[n] = '0; prev_stall[n] = 1'b0; prev_addr[n] = '0;
        end
        // Reset with requests pending: stalls mirror requests, writes not ready
        rd_en = 3'b101;
        cycle();
        cycle();
        chk("rst_stall", s_stall, 3'b101);
        chk("rst_ready", s_ready, 1'b0);
        rst = 1'b0; rd_en = '0;

        // Sixteen back-to-back writes with no readers
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(i);
            cycle();
            if (s_ready) acc++;
        end
        chk("t1_accepted", acc, 16);
        for (int i = 16; i < 32; i++) begin
            wr_addr = AW'(i); wr_data = DW'(32'h100 + i);
            cycle();
        end
        wr_en = 1'b0;

        // Three readers, no writes: each gets valid 2 of every 3 cycles
        rd_addr[0] = 10'h3; rd_addr[1] = 10'h5; rd_addr[2] = 10'h7; rd_en = 3'b111;
        for (int n = 0; n < NP; n++) vcnt[n] = 0;
        for (int i = 0; i < 9; i++) begin
            cycle();
            if (i >= 3) for (int n = 0; n < NP; n++) if (s_valid[n]) vcnt[n]++;
        end
        chk("t2_vcnt0", vcnt[0], 4);
        chk("t2_vcnt1", vcnt[1], 4);
        chk("t2_vcnt2", vcnt[2], 4);
        chk("t2_data", s_data, {32'h7, 32'h5, 32'h3});

        // Continuous writes plus readers: one blocked write cycle in five
        lows = 0;
        for (int n = 0; n < NP; n++) vcnt[n] = 0;
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; wr_addr = AW'(24 + i % 8); wr_data = $urandom;
            cycle();
            if (!s_ready) lows++;
            for (int n = 0; n < NP; n++) if (s_valid[n]) vcnt[n]++;
        end
        chk("t3_lows", lows, 4);
        chk("t3_all_valid", (vcnt[0] > 0) && (vcnt[1] > 0) && (vcnt[2] > 0), 1'b1);
        wr_en = 1'b0;
        drain();

        // Same-cycle write/read collision on 0x10
        wr_en = 1'b1; wr_addr = 10'h10; wr_data = 32'hAA;
        rd_en = 3'b010; rd_addr[1] = 10'h10;
        cycle();
        chk("t4_stall_T", s_stall[1], 1'b1);
        wr_en = 1'b0;
        cycle();
        chk("t4_stall_T1", s_stall[1], 1'b0);
        rd_en = '0;
        cycle();
        chk("t4_valid_T2", s_valid[1], 1'b1);
        chk("t4_data_T2", s_data[1], 32'hAA);

        // Reset right after a grant kills the in-flight return
        rd_en = 3'b001; rd_addr[0] = 10'h3;
        cycle();
        chk("t5_granted", s_stall[0], 1'b0);
        rst = 1'b1; rd_en = '0;
        cycle();
        chk("t5_valid_T1", s_valid[0], 1'b0);
        chk("t5_ready_rst", s_ready, 1'b0);
        rst = 1'b0;
        cycle();
        chk("t5_valid_T2", s_valid[0], 1'b0);
        chk("t5_data_T2", s_data[0], 32'h0);

        // Randomized traffic with collisions and occasional reset
        for (int i = 0; i < 400; i++) begin
            wr_en   = 1'($urandom % 2);
            wr_addr = AW'($urandom % 32);
            wr_data = $urandom;
            rst     = ($urandom % 60) == 0;
            for (int n = 0; n < NP; n++) begin
                if (!prev_stall[n]) begin
                    rd_en[n]   = ($urandom % 3) != 0;
                    rd_addr[n] = AW'($urandom % 32);
                end
            end
            cycle();
        end
        rst = 1'b0; wr_en = 1'b0;
        drain();

        // Two-port instance: lone request on client 1
        d2_wr_en = 1'b1; d2_wr_addr = 10'h5; d2_wr_data = 32'h55;
        @(negedge clk);
        chk("t6_wr_ready", d2_wr_ready, 1'b1);
        @(posedge clk); #1;
        d2_wr_en = 1'b0; d2_rd_en = 2'b10; d2_rd_addr[1] = 10'h5;
        @(negedge clk);
        chk("t6_stall", d2_rd_stall, 2'b00);
        @(posedge clk); #1;
        d2_rd_en = 2'b00;
        @(negedge clk);
        chk("t6_valid", d2_rd_valid, 2'b10);
        chk("t6_data", d2_rd_data[1], 32'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
